// File: rtl/bus_xfer_pkg.sv
// Shared types and opcodes for the bus transfer unit.
// No logic here; pure declarations plus a counter-width helper.
package bus_xfer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SMD  = 2'b01,
      MEM  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FETCH = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/bus_xfer_if.sv
// Request, memory and register-observation signals of the bus transfer unit.
// slave is the unit itself; master is the requester/memory side.
interface bus_xfer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] S_bus;
   logic [WIDTH-1:0] M_bus;
   logic             req_valid;
   logic [1:0]       req_op;
   logic             req_ready;
   logic             mem_ready;
   logic             mem_en;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] MAR_out;
   logic [WIDTH-1:0] MDR_out;
   logic [WIDTH-1:0] IS_out;
   logic             gate_sma;
   logic             gate_smd;
   logic             gate_mmd;
   logic             gate_mis;
   logic             done;
   logic             err;
   logic             busy;

   modport slave (
      input  S_bus, M_bus, req_valid, req_op, mem_ready,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
             MAR_out, MDR_out, IS_out,
             gate_sma, gate_smd, gate_mmd, gate_mis,
             done, err, busy
   );

   modport master (
      output S_bus, M_bus, req_valid, req_op, mem_ready,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
             MAR_out, MDR_out, IS_out,
             gate_sma, gate_smd, gate_mmd, gate_mis,
             done, err, busy
   );
endinterface

// File: rtl/xfer_timer.sv
// Memory wait counter; expired is combinational and fires in the last allowed wait cycle.
// A zero limit never expires; clear holds the count at zero.
module xfer_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] last;

   // Compare against limit-1 so the exit happens on the limit-th stalled cycle.
   assign last    = limit - CNT_W'(1);
   assign expired = enable && (limit != '0) && (count == last);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end
endmodule

// File: rtl/bus_xfer_unit.sv
// MAR/MDR/IS transfer sequencer: read/fetch done at +2, write at +3, illegal at +1 after acceptance.
// Accepts only in IDLE (req_ready); stalls in MEM on mem_ready with an optional timeout.
module bus_xfer_unit
   import bus_xfer_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   bus_xfer_if.slave  bus
);
   localparam int               CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic             err_q, err_nxt;
   logic [WIDTH-1:0] mar, mdr, is_q;
   logic             gate_sma, gate_smd, gate_mmd, gate_mis;
   logic             mem_en, mem_we, done, err;
   logic             tmr_clear, tmr_en, tmr_expired;

   assign tmr_clear = (state != MEM);
   assign tmr_en    = (state == MEM) && !bus.mem_ready;

   xfer_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .limit   (LIMIT),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= OP_READ;
         err_q <= 1'b0;
         mar   <= '0;
         mdr   <= '0;
         is_q  <= '0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (state == IDLE && bus.req_valid) op_q <= bus.req_op;
         if (gate_sma) mar <= bus.S_bus;
         if (gate_smd) mdr <= bus.S_bus;
         else if (gate_mmd) mdr <= bus.M_bus;
         if (gate_mis) is_q <= bus.M_bus;
      end
   end

   // Strobes are suppressed while rst is high so a reset cycle never looks like a transfer.
   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      gate_sma  = 1'b0;
      gate_smd  = 1'b0;
      gate_mmd  = 1'b0;
      gate_mis  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  err_nxt = (bus.req_op == OP_ILL);
                  case (bus.req_op)
                     OP_WRITE: begin
                        gate_sma  = 1'b1;
                        state_nxt = SMD;
                     end
                     OP_ILL: state_nxt = DONE;
                     default: begin
                        gate_sma  = 1'b1;
                        state_nxt = MEM;
                     end
                  endcase
               end
            end
            SMD: begin
               gate_smd  = 1'b1;
               state_nxt = MEM;
            end
            MEM: begin
               mem_en = 1'b1;
               mem_we = (op_q == OP_WRITE);
               if (bus.mem_ready) begin
                  gate_mmd  = (op_q == OP_READ);
                  gate_mis  = (op_q == OP_FETCH);
                  err_nxt   = 1'b0;
                  state_nxt = DONE;
               end else if (tmr_expired) begin
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
               end
            end
            DONE: begin
               done      = 1'b1;
               err       = err_q;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mar;
   assign bus.mem_wdata = mdr;
   assign bus.MAR_out   = mar;
   assign bus.MDR_out   = mdr;
   assign bus.IS_out    = is_q;
   assign bus.gate_sma  = gate_sma;
   assign bus.gate_smd  = gate_smd;
   assign bus.gate_mmd  = gate_mmd;
   assign bus.gate_mis  = gate_mis;
   assign bus.done      = done;
   assign bus.err       = err;
endmodule

// File: tb/tb_bus_xfer_unit.sv
// Scoreboard bench: stimulus pushes model-derived outcomes, a negedge monitor compares on done/mem_en.
module tb_bus_xfer_unit;
   import bus_xfer_pkg::*;

   localparam int T = 8;

   typedef struct {
      logic [1:0]  op;
      logic        err;
      logic [15:0] mar, mdr, is_v, addr, wdata;
      int          done_cyc;
      int          n_sma, n_smd, n_mmd, n_mis, n_mem;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   logic [15:0] m_mar = '0, m_mdr = '0, m_is = '0;
   int   c_sma = 0, c_smd = 0, c_mmd = 0, c_mis = 0, c_mem = 0;

   bus_xfer_if #(.WIDTH(16)) bif ();
   bus_xfer_unit #(.WIDTH(16), .TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bif));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queue head.
   always @(negedge clk) begin
      if (rst) begin
         c_sma = 0; c_smd = 0; c_mmd = 0; c_mis = 0; c_mem = 0;
      end else begin
         check("busy", bif.busy, {31'd0, !bif.req_ready});
         c_sma += int'(bif.gate_sma);
         c_smd += int'(bif.gate_smd);
         c_mmd += int'(bif.gate_mmd);
         c_mis += int'(bif.gate_mis);
         c_mem += int'(bif.mem_en);
         if (bif.gate_mmd || bif.gate_mis) check("gate_needs_mem_ready", bif.mem_ready, 1);
         if (!bif.done) check("err_outside_done", bif.err, 0);
         if (bif.mem_en && sb.size() > 0) begin
            check("mem_addr", bif.mem_addr, sb[0].addr);
            check("mem_we", bif.mem_we, {31'd0, sb[0].op == OP_WRITE});
            if (sb[0].op == OP_WRITE) check("mem_wdata", bif.mem_wdata, sb[0].wdata);
         end
         if (bif.done) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no transfer (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("err", bif.err, e.err);
               check("MAR", bif.MAR_out, e.mar);
               check("MDR", bif.MDR_out, e.mdr);
               check("IS", bif.IS_out, e.is_v);
               check("n_gate_sma", c_sma, e.n_sma);
               check("n_gate_smd", c_smd, e.n_smd);
               check("n_gate_mmd", c_mmd, e.n_mmd);
               check("n_gate_mis", c_mis, e.n_mis);
               check("n_mem_cycles", c_mem, e.n_mem);
            end
            c_sma = 0; c_smd = 0; c_mmd = 0; c_mis = 0; c_mem = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_req(input bit drive_s);
      bif.req_valid = 1'($urandom_range(0, 1));
      bif.req_op    = 2'($urandom);
      if (drive_s) bif.S_bus = 16'($urandom);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !bif.req_ready; i++) step();
      check("req_ready_before_issue", bif.req_ready, 1);
   endtask

   // Reference: memory completes on MEM cycle w+1 unless that exceeds the timeout.
   task automatic xfer(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                       input int w, input logic [15:0] rdata);
      exp_t e;
      bit   to;
      int   n_mem;
      to    = (op != OP_ILL) && (w >= T);
      n_mem = (op == OP_ILL) ? 0 : (to ? T : w + 1);
      wait_ready();
      if (op != OP_ILL) begin
         m_mar = addr;
         if (op == OP_WRITE) m_mdr = wdata;
         if (!to && op == OP_READ)  m_mdr = rdata;
         if (!to && op == OP_FETCH) m_is  = rdata;
      end
      e.op    = op;
      e.err   = (op == OP_ILL) || to;
      e.mar   = m_mar;
      e.mdr   = m_mdr;
      e.is_v  = m_is;
      e.addr  = addr;
      e.wdata = wdata;
      e.done_cyc = cyc + n_mem + 1 + ((op == OP_WRITE) ? 1 : 0);
      e.n_sma = (op == OP_ILL) ? 0 : 1;
      e.n_smd = (op == OP_WRITE) ? 1 : 0;
      e.n_mmd = (op == OP_READ && !to) ? 1 : 0;
      e.n_mis = (op == OP_FETCH && !to) ? 1 : 0;
      e.n_mem = n_mem;
      sb.push_back(e);
      bif.req_valid = 1'b1;
      bif.req_op    = op;
      bif.S_bus     = addr;
      step();
      if (op == OP_WRITE) begin
         junk_req(1'b0);
         bif.S_bus = wdata;
         step();
      end
      for (int i = 0; i < n_mem; i++) begin
         junk_req(1'b1);
         bif.mem_ready = (i == w);
         bif.M_bus     = (i == w) ? rdata : 16'($urandom);
         step();
      end
      bif.mem_ready = 1'b0;
      junk_req(1'b1);
      step();
      bif.req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bif.S_bus     = 16'hFFFF;
      bif.M_bus     = 16'hFFFF;
      bif.req_valid = 1'b1;
      bif.req_op    = OP_READ;
      bif.mem_ready = 1'b0;
      rst = 1'b1;
      step();
      @(negedge clk);
      check("rst_gate_sma", bif.gate_sma, 0);
      check("rst_mem_en", bif.mem_en, 0);
      check("rst_done", bif.done, 0);
      step();
      rst = 1'b0;
      bif.req_valid = 1'b0;
      check("rst_MAR", bif.MAR_out, 16'h0000);
      check("rst_MDR", bif.MDR_out, 16'h0000);
      check("rst_IS", bif.IS_out, 16'h0000);
      check("rst_req_ready", bif.req_ready, 1);
      check("rst_mem_en_after", bif.mem_en, 0);

      xfer(OP_READ,  16'h1234, 16'h0000, 0, 16'hABCD);
      xfer(OP_WRITE, 16'h0040, 16'hAAAA, 0, 16'h0000);
      xfer(OP_FETCH, 16'h0100, 16'h0000, 3, 16'hBEEF);
      xfer(OP_READ,  16'h0200, 16'h0000, T, 16'h5555);
      xfer(OP_ILL,   16'h7777, 16'h0000, 0, 16'h0000);
      xfer(OP_READ,  16'h0300, 16'h0000, T - 1, 16'hC0DE);
      xfer(OP_WRITE, 16'h0400, 16'h1111, T + 1, 16'h0000);
      xfer(OP_FETCH, 16'h0500, 16'h0000, 0, 16'h2222);
      xfer(OP_READ,  16'h0600, 16'h0000, 1, 16'h3333);

      // Reset during the second MEM cycle drops the request without a done pulse.
      wait_ready();
      bif.req_valid = 1'b1;
      bif.req_op    = OP_READ;
      bif.S_bus     = 16'h0ACE;
      step();
      bif.req_valid = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      check("midmem_rst_mem_en", bif.mem_en, 0);
      check("midmem_rst_done", bif.done, 0);
      step();
      rst = 1'b0;
      m_mar = '0; m_mdr = '0; m_is = '0;
      check("midmem_req_ready", bif.req_ready, 1);
      check("midmem_MAR", bif.MAR_out, 16'h0000);
      check("midmem_MDR", bif.MDR_out, 16'h0000);
      check("midmem_IS", bif.IS_out, 16'h0000);
      step();
      step();

      for (int n = 0; n < 40; n++) begin
         int gap;
         int w;
         w = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
         xfer(2'($urandom), 16'($urandom), 16'($urandom), w, 16'($urandom));
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            bif.S_bus = 16'($urandom);
            step();
         end
      end

      step();
      step();
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_xfer_unit.md
BUS_XFER_UNIT -- requirements
Module: bus_xfer_unit

Interface
REQ-001 Parameter WIDTH, default 16: data width of S_bus, M_bus and all data registers.
REQ-002 Parameter TIMEOUT, default 8: maximum MEM cycles waiting for mem_ready; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 S_bus  input  WIDTH  source bus; carries the address at acceptance and write data in the SMD cycle.
REQ-006 M_bus  input  WIDTH  memory read-data bus.
REQ-007 req_valid  input  1  request present.
REQ-008 req_op  input  2  00 read, 01 write, 10 fetch, 11 illegal.
REQ-009 req_ready  output  1  high exactly when state is IDLE.
REQ-010 mem_ready  input  1  memory completion strobe, sampled only in MEM.
REQ-011 mem_en, mem_we  output  1 each  memory strobes.
REQ-012 mem_addr, mem_wdata  output  WIDTH each  driven from MAR and MDR.
REQ-013 MAR_out, MDR_out, IS_out  output  WIDTH each  register contents.
REQ-014 gate_sma, gate_smd, gate_mmd, gate_mis  output  1 each  high in the cycle whose closing edge loads MAR, MDR-from-S, MDR-from-M or IS respectively.
REQ-015 done, err  output  1 each  completion pulse and its error flag.
REQ-016 busy  output  1  equal to !req_ready.

Function
REQ-017 States: IDLE, SMD, MEM, DONE; the FSM changes state only on the clk edge.
REQ-018 In IDLE with req_valid=1: gate_sma=1 and MAR<=S_bus at the edge; ops 00 and 10 go to MEM; op 01 goes to SMD; op 11 goes to DONE with err set and MAR unchanged (gate_sma=0).
REQ-019 In SMD: gate_smd=1; MDR<=S_bus at the edge; go to MEM.
REQ-020 In MEM: mem_en=1; mem_we=1 only for writes; mem_addr=MAR; mem_wdata=MDR; mem_en, mem_we=0 in all other states.
REQ-021 In MEM with mem_ready=1: read asserts gate_mmd and loads MDR<=M_bus; fetch asserts gate_mis and loads IS<=M_bus; write loads nothing; go to DONE with err=0.
REQ-022 Timeout: the wait counter clears on MEM entry and increments each MEM cycle with mem_ready=0; when TIMEOUT!=0 and the count reaches TIMEOUT, go to DONE with err=1 and leave MDR and IS unchanged.
REQ-023 If mem_ready=1 arrives in the cycle the count reaches TIMEOUT, mem_ready wins: normal completion, err=0.
REQ-024 In DONE: done=1 for exactly one cycle and err is valid in that cycle; err=0 outside DONE; next state is IDLE.
REQ-025 Latency from the acceptance edge to done high with mem_ready on the first MEM cycle: read and fetch 2 cycles, write 3 cycles, illegal 1 cycle.
REQ-026 req_valid and req_op are ignored outside IDLE; back-to-back requests are accepted on the cycle after DONE.
REQ-027 MAR, MDR and IS hold their value except at the load edges defined in REQ-018 to REQ-022; no arithmetic is performed on them.

Reset
REQ-028 A rst=1 edge forces IDLE, clears MAR, MDR, IS and the wait counter, and holds done=0, err=0, mem_en=0, mem_we=0 and all gate_* outputs at 0.
REQ-029 rst takes priority in any state, including mid-MEM; the in-flight request is dropped with no done pulse.

Structure
REQ-030 Package bus_xfer_pkg SHALL hold the state enum and the OP_READ/OP_WRITE/OP_FETCH/OP_ILL constants.
REQ-031 The wait counter SHALL be a sub-module xfer_timer (clear, enable, limit inputs; expired output); the FSM and registers stay in bus_xfer_unit.

Verification
REQ-032 Reset: rst high 2 cycles with S_bus=FFFF -> MAR/MDR/IS=0000, req_ready=1, mem_en=0.
REQ-033 Read: op 00, S_bus=1234 at acceptance, mem_ready on the 1st MEM cycle with M_bus=ABCD -> mem_addr=1234, mem_we=0, MDR=ABCD, done 2 cycles after acceptance, err=0.
REQ-034 Write: op 01, S_bus=0040 then AAAA -> in MEM mem_addr=0040, mem_wdata=AAAA, mem_we=1; done at +3; IS unchanged.
REQ-035 Fetch with 3 wait cycles: mem_ready on the 4th MEM cycle, M_bus=BEEF -> IS=BEEF, gate_mis high only in that cycle, MDR unchanged.
REQ-036 Timeout and illegal: TIMEOUT=8 with mem_ready held low -> done with err=1 after 8 MEM cycles, MDR unchanged; op 11 -> done at +1 with err=1, MAR unchanged.
REQ-037 Reset mid-MEM: rst asserted on the 2nd MEM cycle -> IDLE next cycle, no done pulse, registers 0000.
